pe_job_scheduler: RTL and testbench
===================================

PE_JOB_SCHEDULER -- requirements
Module: pe_job_scheduler

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, job queue depth; power of two, minimum 2.
REQ-002 Parameter: TIMEOUT_CYC, 65536, maximum RUN cycles before a job is aborted.
REQ-003 Parameter: ABORT_CYC, 2, cycles pe_rst_n is held low on abort.
REQ-004 aclk  in  1  clock; every register is updated on the rising edge.
REQ-005 aresetn  in  1  synchronous reset, active-low.
REQ-006 job_valid  in  1  a job descriptor is offered.
REQ-007 job_ready  out  1  the queue accepts a descriptor.
REQ-008 job_id  in  4  job tag.
REQ-009 job_src_base  in  32  byte offset added to PE array read addresses.
REQ-010 job_dst_base  in  32  byte offset added to PE array write addresses.
REQ-011 pe_start  out  1  start pulse to the PE array.
REQ-012 pe_done  in  1  done pulse from the PE array.
REQ-013 pe_rst_n  out  1  reset qualifier to the PE array, active-low.
REQ-014 pe_bram_addr  in  32  BRAM address driven by the PE array.
REQ-015 pe_bram_we  in  4  BRAM byte write enables driven by the PE array.
REQ-016 bram_addr  out  32  translated BRAM address.
REQ-017 cmp_valid, cmp_ready  out, in  1, 1  completion handshake.
REQ-018 cmp_id  out  4  tag of the completed job.
REQ-019 cmp_cycles  out  32  RUN-cycle count of the completed job.
REQ-020 cmp_timeout  out  1  the job was aborted.
REQ-021 busy  out  1  (state != IDLE) || queue not empty.
REQ-022 irq  out  1  one-cycle pulse when cmp_valid rises.

Function
REQ-023 The job queue SHALL be a FIFO of FIFO_DEPTH entries; job_ready = !full; a push occurs on job_valid && job_ready.
REQ-024 A push in the same cycle as a pop SHALL keep the occupancy unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 The FSM states SHALL be IDLE, ISSUE, RUN, ABORT and REPORT.
REQ-026 IDLE SHALL go to ISSUE when the queue is not empty, popping the head into an active-job register in that cycle; a job pushed into an empty queue SHALL reach ISSUE no earlier than the next cycle.
REQ-027 ISSUE SHALL assert pe_start for exactly one cycle, clear the cycle counter to 0, and go to RUN.
REQ-028 RUN SHALL increment the cycle counter every cycle, including the cycle in which pe_done is seen.
REQ-029 If pe_done = 1 in RUN, the FSM SHALL go to REPORT with cmp_timeout = 0.
REQ-030 In RUN, pe_done SHALL take priority over a timeout occurring in the same cycle.
REQ-031 If the counter reaches TIMEOUT_CYC without pe_done, the FSM SHALL go to ABORT.
REQ-032 ABORT SHALL drive pe_rst_n = 0 for ABORT_CYC cycles, then go to REPORT with cmp_timeout = 1 and cmp_cycles = TIMEOUT_CYC.
REQ-033 pe_done SHALL be ignored in every state other than RUN.
REQ-034 REPORT SHALL hold cmp_valid, cmp_id, cmp_cycles and cmp_timeout stable until cmp_ready = 1, then go to IDLE.
REQ-035 irq SHALL pulse in the first cycle of cmp_valid.
REQ-036 bram_addr = pe_bram_addr + (|pe_bram_we ? dst_base : src_base) of the active job, combinational, with 32-bit wrap-around; in IDLE, bram_addr = pe_bram_addr.
REQ-037 The cycle counter SHALL saturate at 2^32-1.

Reset
REQ-038 While aresetn = 0: FSM goes to IDLE, queue empties, job_ready = 0, pe_start = 0, pe_rst_n = 0, cmp_valid = 0, cmp_id = 0, cmp_cycles = 0, cmp_timeout = 0, busy = 0, irq = 0.
REQ-039 In the first cycle after reset release, job_ready = 1 and pe_rst_n = 1.
REQ-040 Reset asserted mid-job SHALL discard the active job and every queued job without producing a completion.

Verification
REQ-041 Push id=3, src=0x100, dst=0x800; pe_done 10 cycles after pe_start; pe_bram_addr=0x4 read then write -> bram_addr 0x104 then 0x804; cmp_id=3, cmp_cycles=10, cmp_timeout=0, one irq pulse.
REQ-042 Push 5 jobs back-to-back with the PE array stalled -> job_ready=0 after the 4th push; all 4 complete in order with ids 0..3.
REQ-043 TIMEOUT_CYC=8, pe_done never asserted -> pe_rst_n low for 2 cycles; cmp_timeout=1, cmp_cycles=8.
REQ-044 pe_done in the same cycle the counter reaches TIMEOUT_CYC -> normal completion, cmp_timeout=0.
REQ-045 cmp_ready held low for 20 cycles -> completion fields stable, no new pe_start; the next job issues after cmp_ready is accepted.
REQ-046 aresetn pulsed low during RUN with 2 jobs queued -> no completion, busy=0, queue empty.

Source files
------------

// File: rtl/pe_job_scheduler.sv
// Purpose : queues PE-array job descriptors, issues them one at a time, times each run,
//           aborts runs that hang and reports every completion over a valid/ready port.
// Latency : a job pushed into an idle, empty scheduler sees pe_start two cycles later;
//           the completion appears the cycle after pe_done (or after the abort window).
// Backpressure: job_ready drops while the queue is full; a completion is held in REPORT
//           until cmp_ready, and no further job issues until then.
// Ports   : aclk/aresetn (sync, active-low); job_valid/job_ready/job_id/job_src_base/
//           job_dst_base (descriptor in); pe_start/pe_done/pe_rst_n (PE array control);
//           pe_bram_addr/pe_bram_we -> bram_addr (address translation); cmp_valid/
//           cmp_ready/cmp_id/cmp_cycles/cmp_timeout (completion out); busy, irq.

// Purpose : generic synchronous FIFO, power-of-two depth, head word shown combinationally.
// Latency : a pushed word is visible at the head the cycle after the push.
// Backpressure: pushes are dropped while full, pops are ignored while empty.
module pe_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module pe_job_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65536,
    parameter int ABORT_CYC   = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [3:0]  job_id,
    input  logic [31:0] job_src_base,
    input  logic [31:0] job_dst_base,
    output logic        pe_start,
    input  logic        pe_done,
    output logic        pe_rst_n,
    input  logic [31:0] pe_bram_addr,
    input  logic [3:0]  pe_bram_we,
    output logic [31:0] bram_addr,
    output logic        cmp_valid,
    input  logic        cmp_ready,
    output logic [3:0]  cmp_id,
    output logic [31:0] cmp_cycles,
    output logic        cmp_timeout,
    output logic        busy,
    output logic        irq
);
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] src_base;
        logic [31:0] dst_base;
    } job_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_ABORT  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]  state;
    job_t        push_job;
    job_t        head_job;
    job_t        act_job;
    logic        q_full;
    logic        q_empty;
    logic        q_pop;
    logic [31:0] run_cnt;
    logic [31:0] cnt_inc;
    logic [31:0] abort_cnt;
    logic        timeout_hit;
    logic        abort_last;
    logic        timeout_q;
    logic        cmp_valid_q;

    assign push_job = '{id: job_id, src_base: job_src_base, dst_base: job_dst_base};
    assign q_pop    = (state == S_IDLE) && !q_empty;

    pe_job_fifo #(
        .WIDTH ($bits(job_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_job_q (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push_vld (job_valid),
        .push_dat (push_job),
        .pop_rdy  (q_pop),
        .head_dat (head_job),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Saturating increment; the timeout test looks at the value the counter is about
    // to take, so a job aborts in the cycle its count reaches TIMEOUT_CYC.
    assign cnt_inc     = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
    assign timeout_hit = ({1'b0, cnt_inc} >= 33'(TIMEOUT_CYC));
    assign abort_last  = (abort_cnt == 32'(ABORT_CYC - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            act_job     <= '0;
            run_cnt     <= '0;
            abort_cnt   <= '0;
            timeout_q   <= 1'b0;
            cmp_valid_q <= 1'b0;
        end else begin
            cmp_valid_q <= (state == S_REPORT);
            case (state)
                S_IDLE: begin
                    if (!q_empty) begin
                        act_job <= head_job;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    run_cnt <= '0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    run_cnt <= cnt_inc;
                    // pe_done wins over a timeout landing in the same cycle.
                    if (pe_done) begin
                        timeout_q <= 1'b0;
                        state     <= S_REPORT;
                    end else if (timeout_hit) begin
                        run_cnt   <= 32'(TIMEOUT_CYC);
                        timeout_q <= 1'b1;
                        abort_cnt <= '0;
                        state     <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    abort_cnt <= abort_cnt + 32'd1;
                    if (abort_last) state <= S_REPORT;
                end
                S_REPORT: begin
                    if (cmp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // aresetn gates these directly so they are low for the whole reset window and
    // come back high in the very first cycle after release.
    assign job_ready   = aresetn && !q_full;
    assign pe_rst_n    = aresetn && (state != S_ABORT);

    assign pe_start    = (state == S_ISSUE);
    assign cmp_valid   = (state == S_REPORT);
    assign cmp_id      = act_job.id;
    assign cmp_cycles  = run_cnt;
    assign cmp_timeout = timeout_q;
    assign busy        = (state != S_IDLE) || !q_empty;
    assign irq         = cmp_valid && !cmp_valid_q;

    // Any byte-enable marks a write; the active job stays latched from ISSUE to REPORT.
    always_comb begin
        bram_addr = pe_bram_addr;
        if (state != S_IDLE) begin
            bram_addr = pe_bram_addr + ((|pe_bram_we) ? act_job.dst_base : act_job.src_base);
        end
    end
endmodule

// File: tb/tb_pe_job_scheduler.sv
module tb_pe_job_scheduler;
    localparam int T_MAIN  = 64;
    localparam int T_SHORT = 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        job_valid = 1'b0;
    logic [3:0]  job_id = '0;
    logic [31:0] job_src_base = '0;
    logic [31:0] job_dst_base = '0;
    logic        pe_done = 1'b0;
    logic [31:0] pe_bram_addr = '0;
    logic [3:0]  pe_bram_we = '0;
    logic        cmp_ready = 1'b0;

    logic        job_ready, pe_start, pe_rst_n, cmp_valid, cmp_timeout, busy, irq;
    logic [31:0] bram_addr, cmp_cycles;
    logic [3:0]  cmp_id;
    logic        job_ready_s, pe_start_s, pe_rst_n_s, cmp_valid_s, cmp_timeout_s, busy_s, irq_s;
    logic [31:0] bram_addr_s, cmp_cycles_s;
    logic [3:0]  cmp_id_s;

    pe_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T_MAIN), .ABORT_CYC(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .job_valid(job_valid), .job_ready(job_ready),
        .job_id(job_id), .job_src_base(job_src_base), .job_dst_base(job_dst_base),
        .pe_start(pe_start), .pe_done(pe_done), .pe_rst_n(pe_rst_n),
        .pe_bram_addr(pe_bram_addr), .pe_bram_we(pe_bram_we), .bram_addr(bram_addr),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
        .cmp_cycles(cmp_cycles), .cmp_timeout(cmp_timeout), .busy(busy), .irq(irq));

    pe_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYC(T_SHORT), .ABORT_CYC(2)) dut_s (
        .aclk(aclk), .aresetn(aresetn), .job_valid(job_valid), .job_ready(job_ready_s),
        .job_id(job_id), .job_src_base(job_src_base), .job_dst_base(job_dst_base),
        .pe_start(pe_start_s), .pe_done(pe_done), .pe_rst_n(pe_rst_n_s),
        .pe_bram_addr(pe_bram_addr), .pe_bram_we(pe_bram_we), .bram_addr(bram_addr_s),
        .cmp_valid(cmp_valid_s), .cmp_ready(cmp_ready), .cmp_id(cmp_id_s),
        .cmp_cycles(cmp_cycles_s), .cmp_timeout(cmp_timeout_s), .busy(busy_s), .irq(irq_s));

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] exp;
    } bvec_t;
    bvec_t vt [5];

    typedef struct {
        logic [3:0]  id;
        logic [31:0] src;
        logic [31:0] dst;
    } job_s;

    // reference model state for the randomized phase
    job_s q[$];
    job_s run_job;
    bit   in_job = 0;
    bit   acc = 0;
    int   pend = 0;
    int   exp_cyc = 0;
    bit   exp_to = 0;
    int   comps = 0;
    int   irqs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return pe_start;
            1:       return cmp_valid;
            2:       return pe_start_s;
            default: return cmp_valid_s;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            settle();
            if (sel(w)) begin
                seen = 1;
                break;
            end
            next();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0; job_valid = 1'b0; pe_done = 1'b0; cmp_ready = 1'b0;
        pe_bram_addr = '0; pe_bram_we = '0;
        repeat (3) next();
        aresetn = 1'b1;
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] src, input logic [31:0] dst);
        job_valid = 1'b1; job_id = id; job_src_base = src; job_dst_base = dst;
        settle();
        for (int i = 0; i < 400 && !job_ready; i++) begin
            next();
            settle();
        end
        check("push_accept", 32'(job_ready), 32'd1);
        next();
        job_valid = 1'b0;
    endtask

    task automatic accept_cmp(input logic [3:0] exp_id);
        wait_for(1, "cmp_seen");
        check("cmp_id_order", 32'(cmp_id), 32'(exp_id));
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;
    endtask

    task automatic run_main_job(input int lat, input logic [3:0] exp_id);
        wait_for(0, "start_seen");
        for (int k = 1; k <= lat; k++) begin
            next();
            pe_done = (k == lat);
        end
        next();
        pe_done = 1'b0;
        settle();
        check("job_cmp_valid", 32'(cmp_valid), 32'd1);
        check("job_cmp_id", 32'(cmp_id), 32'(exp_id));
        check("job_cmp_cycles", cmp_cycles, 32'(lat));
        check("job_cmp_timeout", 32'(cmp_timeout), 32'd0);
        check("job_irq", 32'(irq), 32'd1);
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;
    endtask

    // One cycle of the randomized run: drive, then sample and update the model.
    task automatic rand_cycle(input bit allow_new);
        int l;
        logic [31:0] exp_addr;
        next();
        if (acc) job_valid = 1'b0;
        acc = 0;
        if (pend > 0) begin
            pend--;
            pe_done = (pend == 0);
        end else begin
            pe_done = 1'b0;
        end
        if (allow_new && !job_valid && $urandom_range(0, 9) < 4) begin
            job_valid = 1'b1;
            job_id = 4'($urandom);
            job_src_base = $urandom;
            job_dst_base = $urandom;
        end
        cmp_ready = allow_new ? ($urandom_range(0, 9) < 7) : 1'b1;
        pe_bram_addr = $urandom;
        pe_bram_we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        settle();

        if (pe_start) begin
            if (q.size() == 0) begin
                check("rnd_start_with_empty_model", 32'd1, 32'd0);
            end else begin
                run_job = q.pop_front();
                in_job = 1;
                l = $urandom_range(1, 80);
                pend = l;
                exp_to = (l > T_MAIN);
                exp_cyc = exp_to ? T_MAIN : l;
            end
        end
        if (!pe_rst_n) pend = 0;

        check("rnd_job_ready", 32'(job_ready), 32'(q.size() < 4));
        exp_addr = pe_bram_addr;
        if (in_job) exp_addr = pe_bram_addr + ((pe_bram_we != 4'h0) ? run_job.dst : run_job.src);
        check("rnd_bram_addr", bram_addr, exp_addr);
        if (irq) irqs++;
        if (cmp_valid && !in_job) check("rnd_cmp_without_job", 32'd1, 32'd0);
        if (cmp_valid && cmp_ready && in_job) begin
            check("rnd_cmp_id", 32'(cmp_id), 32'(run_job.id));
            check("rnd_cmp_cycles", cmp_cycles, 32'(exp_cyc));
            check("rnd_cmp_timeout", 32'(cmp_timeout), 32'(exp_to));
            comps++;
            in_job = 0;
        end
        if (job_valid && job_ready) begin
            q.push_back('{id: job_id, src: job_src_base, dst: job_dst_base});
            acc = 1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lows;
        int first_rep;
        int pulses;
        bit done;

        vt[0] = '{addr: 32'h0000_0004, we: 4'h0, exp: 32'h0000_0104};
        vt[1] = '{addr: 32'h0000_0004, we: 4'h1, exp: 32'h0000_0804};
        vt[2] = '{addr: 32'hFFFF_F900, we: 4'h8, exp: 32'h0000_0100};
        vt[3] = '{addr: 32'hFFFF_FF00, we: 4'h0, exp: 32'h0000_0000};
        vt[4] = '{addr: 32'h0000_0010, we: 4'hF, exp: 32'h0000_0810};

        // reset values
        aresetn = 1'b0;
        repeat (3) next();
        settle();
        check("rst_job_ready", 32'(job_ready), 32'd0);
        check("rst_pe_rst_n", 32'(pe_rst_n), 32'd0);
        check("rst_pe_start", 32'(pe_start), 32'd0);
        check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("rst_cmp_id", 32'(cmp_id), 32'd0);
        check("rst_cmp_cycles", cmp_cycles, 32'd0);
        check("rst_cmp_timeout", 32'(cmp_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        next();
        aresetn = 1'b1;
        settle();
        check("post_rst_job_ready", 32'(job_ready), 32'd1);
        check("post_rst_pe_rst_n", 32'(pe_rst_n), 32'd1);

        // basic job with address translation table
        pe_bram_addr = 32'h1234; pe_bram_we = 4'hF;
        settle();
        check("idle_passthrough", bram_addr, 32'h1234);
        push(4'd3, 32'h100, 32'h800);
        wait_for(0, "basic_start");
        for (int k = 1; k <= 10; k++) begin
            next();
            if (k <= 5) begin
                pe_bram_addr = vt[k-1].addr;
                pe_bram_we = vt[k-1].we;
                settle();
                check($sformatf("bram_vec_%0d", k - 1), bram_addr, vt[k-1].exp);
            end
            pe_done = (k == 10);
        end
        next();
        pe_done = 1'b0;
        settle();
        check("basic_cmp_valid", 32'(cmp_valid), 32'd1);
        check("basic_cmp_id", 32'(cmp_id), 32'd3);
        check("basic_cmp_cycles", cmp_cycles, 32'd10);
        check("basic_cmp_timeout", 32'(cmp_timeout), 32'd0);
        check("basic_irq_first", 32'(irq), 32'd1);
        next();
        settle();
        check("basic_irq_second", 32'(irq), 32'd0);
        check("basic_cmp_hold", 32'(cmp_valid), 32'd1);
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;
        settle();
        check("basic_cmp_cleared", 32'(cmp_valid), 32'd0);
        check("basic_idle_busy", 32'(busy), 32'd0);

        // queue fill while the PE array is stalled
        push(4'd9, 32'h0, 32'h0);
        wait_for(0, "stall_start");
        for (int i = 0; i < 5; i++) begin
            next();
            job_valid = 1'b1; job_id = 4'(i); job_src_base = 32'(i); job_dst_base = 32'(i);
            settle();
            check($sformatf("fill_ready_%0d", i), 32'(job_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        bad = 0;
        repeat (3) begin
            next();
            settle();
            if (job_ready) bad++;
        end
        check("full_ready_stays_low", 32'(bad), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        job_valid = 1'b0;
        next();
        pe_done = 1'b1;
        next();
        pe_done = 1'b0;
        accept_cmp(4'd9);
        for (int i = 0; i < 4; i++) run_main_job(3 + i, 4'(i));
        settle();
        check("fill_drained_busy", 32'(busy), 32'd0);

        // completion held while cmp_ready is low
        push(4'd1, 32'h0, 32'h0);
        push(4'd2, 32'h0, 32'h0);
        wait_for(0, "hold_start");
        for (int k = 1; k <= 3; k++) begin
            next();
            pe_done = (k == 3);
        end
        next();
        pe_done = 1'b0;
        bad = 0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (!cmp_valid || cmp_id != 4'd1 || cmp_cycles != 32'd3 || cmp_timeout || pe_start) bad++;
            if (irq) pulses++;
            next();
        end
        check("hold_fields_stable", 32'(bad), 32'd0);
        check("hold_single_irq", 32'(pulses), 32'd1);
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;
        run_main_job(4, 4'd2);

        // reset mid-run discards everything
        push(4'd7, 32'h0, 32'h0);
        wait_for(0, "abort_rst_start");
        push(4'd8, 32'h0, 32'h0);
        push(4'd9, 32'h0, 32'h0);
        next();
        aresetn = 1'b0;
        next();
        settle();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("midrst_pe_rst_n", 32'(pe_rst_n), 32'd0);
        next();
        aresetn = 1'b1;
        settle();
        check("midrst_busy_after", 32'(busy), 32'd0);
        check("midrst_job_ready_after", 32'(job_ready), 32'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            next();
            settle();
            if (pe_start || cmp_valid || busy) bad++;
        end
        check("midrst_no_activity", 32'(bad), 32'd0);

        // timeout on the short instance, with a stray pe_done during ABORT
        do_reset();
        push(4'd5, 32'h0, 32'h0);
        wait_for(2, "to_start");
        lows = 0; first_rep = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            next();
            pe_done = (k == 9);
            settle();
            if (!pe_rst_n_s) lows++;
            if (cmp_valid_s && first_rep == 0) first_rep = k;
            if (irq_s) pulses++;
        end
        pe_done = 1'b0;
        check("to_rst_low_cycles", 32'(lows), 32'd2);
        check("to_report_cycle", 32'(first_rep), 32'd11);
        check("to_cmp_timeout", 32'(cmp_timeout_s), 32'd1);
        check("to_cmp_cycles", cmp_cycles_s, 32'd8);
        check("to_cmp_id", 32'(cmp_id_s), 32'd5);
        check("to_irq_pulses", 32'(pulses), 32'd1);
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;

        // pe_done on the cycle the count reaches the timeout
        do_reset();
        push(4'd6, 32'h0, 32'h0);
        wait_for(2, "edge_start");
        lows = 0;
        for (int k = 1; k <= 8; k++) begin
            next();
            pe_done = (k == 8);
            settle();
            if (!pe_rst_n_s) lows++;
        end
        next();
        pe_done = 1'b0;
        settle();
        if (!pe_rst_n_s) lows++;
        check("edge_cmp_valid", 32'(cmp_valid_s), 32'd1);
        check("edge_cmp_timeout", 32'(cmp_timeout_s), 32'd0);
        check("edge_cmp_cycles", cmp_cycles_s, 32'd8);
        check("edge_no_abort", 32'(lows), 32'd0);
        cmp_ready = 1'b1;
        next();
        cmp_ready = 1'b0;

        // randomized traffic against the reference model
        do_reset();
        q.delete();
        in_job = 0; acc = 0; pend = 0; comps = 0; irqs = 0;
        for (int c = 0; c < 4000; c++) rand_cycle(1'b1);
        done = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(1'b0);
            if (!job_valid && !in_job && q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        check("rnd_drained", 32'(done), 32'd1);
        check("rnd_irq_vs_completions", 32'(irqs), 32'(comps));
        check("rnd_enough_completions", 32'(comps > 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
